// File: rtl/mest_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : mest_result_collector
// Purpose  : Launches a processor run, captures its flagged results into a
//            FIFO and lets the host drain them.
// Revision : 1.0 - initial release
// ============================================================================
module mest_result_collector #(
  parameter int DATA_WIDTH     = 8,
  parameter int FIFO_DEPTH     = 16,
  parameter int START_DELAY    = 10,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          i_reset_n,
  input  logic                          i_go,
  output logic                          o_start,
  input  logic [DATA_WIDTH-1:0]         i_result,
  input  logic                          i_valid_result,
  input  logic                          i_carry,
  input  logic                          i_zero_flag,
  input  logic                          i_all_done,
  input  logic                          i_rd_en,
  output logic [DATA_WIDTH+1:0]         o_rd_data,
  output logic                          o_rd_valid,
  output logic                          o_empty,
  output logic                          o_full,
  output logic [$clog2(FIFO_DEPTH):0]   o_count,
  output logic [15:0]                   o_result_total,
  output logic                          o_overflow,
  output logic                          o_timeout,
  output logic                          o_busy,
  output logic                          o_run_done
);

  localparam int c_AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int c_EW    = DATA_WIDTH + 2;
  localparam int c_DLY_W = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
  localparam int c_TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_DLY_W-1:0]   r_dly_cnt;
  logic [c_TMO_W-1:0]   r_tmo_cnt;
  logic [c_EW-1:0]      r_mem [FIFO_DEPTH];
  logic [c_AW-1:0]      r_wr_ptr;
  logic [c_AW-1:0]      r_rd_ptr;
  logic [c_CW-1:0]      r_count;
  logic [15:0]          r_total;
  logic [c_EW-1:0]      r_rd_data;
  logic                 r_rd_valid;
  logic                 r_overflow;
  logic                 r_timeout;
  logic                 r_start;
  logic                 r_busy;
  logic                 r_run_done;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_res_in;
  logic w_push;
  logic w_drop;
  logic w_launch;
  logic w_dly_end;
  logic w_tmo_hit;

  always_comb begin
    w_full    = (r_count == c_CW'(FIFO_DEPTH));
    w_empty   = (r_count == '0);
    w_pop     = i_rd_en && !w_empty;
    w_res_in  = (r_state == S_RUN) && i_valid_result;
    // A pop in the same cycle frees the slot the incoming result needs.
    w_push    = w_res_in && (!w_full || w_pop);
    w_drop    = w_res_in && w_full && !w_pop;
    w_launch  = i_go && ((r_state == S_IDLE) || (r_state == S_DONE));
    w_dly_end = (r_dly_cnt == c_DLY_W'(START_DELAY - 1));
    w_tmo_hit = (r_state == S_RUN) && !i_valid_result && !i_all_done &&
                (r_tmo_cnt == c_TMO_W'(TIMEOUT_CYCLES - 1));
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_launch) w_state_nxt = S_WAIT;
      S_WAIT:  if (w_dly_end) w_state_nxt = S_START;
      S_START: w_state_nxt = S_RUN;
      S_RUN:   if (i_all_done || w_tmo_hit) w_state_nxt = S_DONE;
      S_DONE:  if (w_launch) w_state_nxt = S_WAIT;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_start    <= 1'b0;
      r_busy     <= 1'b0;
      r_run_done <= 1'b0;
      r_dly_cnt  <= '0;
      r_tmo_cnt  <= '0;
    end else begin
      r_start    <= (w_state_nxt == S_START);
      r_busy     <= (w_state_nxt == S_WAIT) || (w_state_nxt == S_START) ||
                    (w_state_nxt == S_RUN);
      r_run_done <= (w_state_nxt == S_DONE);
      r_dly_cnt  <= (r_state == S_WAIT) ? r_dly_cnt + c_DLY_W'(1) : '0;
      r_tmo_cnt  <= ((r_state == S_RUN) && !i_valid_result) ?
                    r_tmo_cnt + c_TMO_W'(1) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {i_carry, i_zero_flag, i_result};
    end
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_total    <= '0;
      r_overflow <= 1'b0;
      r_timeout  <= 1'b0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_pop;
      if (w_pop) begin
        r_rd_data <= r_mem[r_rd_ptr];
      end
      if (w_launch) begin
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_count    <= '0;
        r_total    <= '0;
        r_overflow <= 1'b0;
        r_timeout  <= 1'b0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + c_AW'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + c_AW'(1);
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + c_CW'(1);
          2'b01:   r_count <= r_count - c_CW'(1);
          default: r_count <= r_count;
        endcase
        if (w_push && (r_total != 16'hFFFF)) begin
          r_total <= r_total + 16'd1;
        end
        if (w_drop) begin
          r_overflow <= 1'b1;
        end
        if (w_tmo_hit) begin
          r_timeout <= 1'b1;
        end
      end
    end
  end

  assign o_start        = r_start;
  assign o_busy         = r_busy;
  assign o_run_done     = r_run_done;
  assign o_rd_data      = r_rd_data;
  assign o_rd_valid     = r_rd_valid;
  assign o_count        = r_count;
  assign o_empty        = w_empty;
  assign o_full         = w_full;
  assign o_result_total = r_total;
  assign o_overflow     = r_overflow;
  assign o_timeout      = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_mest_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_mest_result_collector
// Purpose  : Directed, table-driven checks of the result collector.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mest_result_collector;

  logic        clk = 1'b0;
  logic        i_reset_n = 1'b1;
  logic        i_go = 1'b0;
  logic        o_start;
  logic [7:0]  i_result = '0;
  logic        i_valid_result = 1'b0;
  logic        i_carry = 1'b0;
  logic        i_zero_flag = 1'b0;
  logic        i_all_done = 1'b0;
  logic        i_rd_en = 1'b0;
  logic [9:0]  o_rd_data;
  logic        o_rd_valid;
  logic        o_empty;
  logic        o_full;
  logic [4:0]  o_count;
  logic [15:0] o_result_total;
  logic        o_overflow;
  logic        o_timeout;
  logic        o_busy;
  logic        o_run_done;

  int n_chk  = 0;
  int n_fail = 0;

  mest_result_collector #(
    .DATA_WIDTH(8), .FIFO_DEPTH(16), .START_DELAY(10), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .i_reset_n(i_reset_n), .i_go(i_go), .o_start(o_start),
    .i_result(i_result), .i_valid_result(i_valid_result), .i_carry(i_carry),
    .i_zero_flag(i_zero_flag), .i_all_done(i_all_done), .i_rd_en(i_rd_en),
    .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid), .o_empty(o_empty),
    .o_full(o_full), .o_count(o_count), .o_result_total(o_result_total),
    .o_overflow(o_overflow), .o_timeout(o_timeout), .o_busy(o_busy),
    .o_run_done(o_run_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic [7:0] res;
    logic       c;
    logic       z;
    logic       done;
    logic       rd;
    int         e_count;
    int         e_total;
    logic       e_rdv;
    logic [9:0] e_data;
    logic       e_done;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues i_go in cycle 0 and returns in cycle 12 (first RUN cycle).
  task automatic launch(input string tag);
    int n_hi;
    int first_hi;
    n_hi = 0;
    first_hi = -1;
    i_go = 1'b1;
    tick();
    i_go = 1'b0;
    chk({tag, " busy@1"}, 32'(o_busy), 32'd1);
    chk({tag, " flush count"}, 32'(o_count), 32'd0);
    chk({tag, " clr total"}, 32'(o_result_total), 32'd0);
    chk({tag, " clr ovf/tmo"}, {30'd0, o_overflow, o_timeout}, 32'd0);
    for (int c = 1; c <= 12; c++) begin
      if (o_start === 1'b1) begin
        n_hi++;
        if (first_hi < 0) first_hi = c;
      end
      if (c < 12) tick();
    end
    chk({tag, " start cycles"}, 32'(n_hi), 32'd1);
    chk({tag, " start@"}, 32'(first_hi), 32'd11);
    chk({tag, " busy@12"}, 32'(o_busy), 32'd1);
  endtask

  initial begin
    // Capture, DONE-state ignore, and pop sequence starting at RUN entry.
    vecs[0] = '{1'b1, 8'd5,   1'b0, 1'b0, 1'b0, 1'b0, 1, 1, 1'b0, 10'h000, 1'b0};
    vecs[1] = '{1'b1, 8'd0,   1'b0, 1'b1, 1'b0, 1'b0, 2, 2, 1'b0, 10'h000, 1'b0};
    vecs[2] = '{1'b1, 8'd255, 1'b1, 1'b0, 1'b0, 1'b0, 3, 3, 1'b0, 10'h000, 1'b0};
    vecs[3] = '{1'b0, 8'd0,   1'b0, 1'b0, 1'b1, 1'b0, 3, 3, 1'b0, 10'h000, 1'b1};
    vecs[4] = '{1'b0, 8'd0,   1'b0, 1'b0, 1'b0, 1'b1, 2, 3, 1'b1, 10'h005, 1'b1};
    vecs[5] = '{1'b0, 8'd0,   1'b0, 1'b0, 1'b0, 1'b1, 1, 3, 1'b1, 10'h100, 1'b1};
    vecs[6] = '{1'b0, 8'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1, 3, 1'b0, 10'h100, 1'b1};
    vecs[7] = '{1'b0, 8'd0,   1'b0, 1'b0, 1'b0, 1'b1, 0, 3, 1'b1, 10'h2FF, 1'b1};
    vecs[8] = '{1'b0, 8'd0,   1'b0, 1'b0, 1'b0, 1'b1, 0, 3, 1'b0, 10'h2FF, 1'b1};
    vecs[9] = '{1'b1, 8'd7,   1'b0, 1'b0, 1'b1, 1'b0, 0, 3, 1'b0, 10'h2FF, 1'b1};

    #3 i_reset_n = 1'b0;
    tick();
    tick();
    chk("rst busy/done/start", {29'd0, o_busy, o_run_done, o_start}, 32'd0);
    chk("rst count", 32'(o_count), 32'd0);
    chk("rst empty/full", {30'd0, o_empty, o_full}, 32'b10);
    chk("rst rd", {21'd0, o_rd_valid, o_rd_data}, 32'd0);
    chk("rst flags/total", {14'd0, o_overflow, o_timeout, o_result_total}, 32'd0);
    i_reset_n = 1'b1;
    tick();

    // Capture and pops
    launch("cap");
    for (int i = 0; i < 10; i++) begin
      i_valid_result = vecs[i].valid;
      i_result       = vecs[i].res;
      i_carry        = vecs[i].c;
      i_zero_flag    = vecs[i].z;
      i_all_done     = vecs[i].done;
      i_rd_en        = vecs[i].rd;
      tick();
      chk($sformatf("v%0d count", i), 32'(o_count), 32'(vecs[i].e_count));
      chk($sformatf("v%0d total", i), 32'(o_result_total), 32'(vecs[i].e_total));
      chk($sformatf("v%0d rd_valid", i), 32'(o_rd_valid), 32'(vecs[i].e_rdv));
      chk($sformatf("v%0d rd_data", i), 32'(o_rd_data), 32'(vecs[i].e_data));
      chk($sformatf("v%0d run_done", i), 32'(o_run_done), 32'(vecs[i].e_done));
      chk($sformatf("v%0d empty", i), 32'(o_empty), 32'(vecs[i].e_count == 0));
    end
    i_valid_result = 1'b0; i_all_done = 1'b0; i_rd_en = 1'b0;
    i_carry = 1'b0; i_zero_flag = 1'b0;

    // Overflow: 17 results, no pops
    launch("ovf");
    for (int i = 0; i < 17; i++) begin
      i_valid_result = 1'b1;
      i_result = 8'(i);
      tick();
      if (i == 15) begin
        chk("ovf full@16", 32'(o_full), 32'd1);
        chk("ovf not yet", 32'(o_overflow), 32'd0);
      end
    end
    i_valid_result = 1'b0;
    chk("ovf count", 32'(o_count), 32'd16);
    chk("ovf full", 32'(o_full), 32'd1);
    chk("ovf flag", 32'(o_overflow), 32'd1);
    chk("ovf total", 32'(o_result_total), 32'd16);
    i_all_done = 1'b1;
    tick();
    i_all_done = 1'b0;
    chk("ovf done", 32'(o_run_done), 32'd1);

    // Full + pop + result in the same cycle, then drain across the wrap
    launch("fpr");
    for (int i = 0; i < 16; i++) begin
      i_valid_result = 1'b1;
      i_result = 8'(8'h10 + i);
      tick();
    end
    i_result = 8'h40;
    i_rd_en = 1'b1;
    tick();
    i_valid_result = 1'b0;
    i_rd_en = 1'b0;
    chk("fpr count", 32'(o_count), 32'd16);
    chk("fpr ovf", 32'(o_overflow), 32'd0);
    chk("fpr total", 32'(o_result_total), 32'd17);
    chk("fpr rd_valid", 32'(o_rd_valid), 32'd1);
    chk("fpr rd_data", 32'(o_rd_data), 32'h010);
    i_all_done = 1'b1;
    tick();
    i_all_done = 1'b0;
    i_rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk($sformatf("drain%0d", i), 32'(o_rd_data), (i < 15) ? 32'(8'h11 + i) : 32'h040);
    end
    i_rd_en = 1'b0;
    tick();
    chk("drain empty", {27'd0, o_empty, o_count}, 32'h20);

    // Timeout with no results
    launch("tmo");
    repeat (7) tick();
    chk("tmo early", {30'd0, o_run_done, o_timeout}, 32'd0);
    tick();
    chk("tmo done", 32'(o_run_done), 32'd1);
    chk("tmo flag", 32'(o_timeout), 32'd1);
    chk("tmo total", 32'(o_result_total), 32'd0);
    i_rd_en = 1'b1;
    tick();
    i_rd_en = 1'b0;
    chk("tmo pop empty", 32'(o_rd_valid), 32'd0);
    chk("tmo count", 32'(o_count), 32'd0);

    // Reset mid-RUN with 4 queued, then a normal run
    launch("rst1");
    for (int i = 0; i < 4; i++) begin
      i_valid_result = 1'b1;
      i_result = 8'(8'hA0 + i);
      tick();
    end
    i_valid_result = 1'b0;
    chk("mid count pre", 32'(o_count), 32'd4);
    i_reset_n = 1'b0;
    #2;
    chk("mid count", 32'(o_count), 32'd0);
    chk("mid empty", 32'(o_empty), 32'd1);
    chk("mid idle", {29'd0, o_busy, o_run_done, o_start}, 32'd0);
    chk("mid total", 32'(o_result_total), 32'd0);
    tick();
    i_reset_n = 1'b1;
    tick();
    launch("rst2");
    i_valid_result = 1'b1;
    i_result = 8'h3C;
    i_carry = 1'b1;
    i_all_done = 1'b1;
    tick();
    i_valid_result = 1'b0;
    i_carry = 1'b0;
    i_all_done = 1'b0;
    chk("post done", 32'(o_run_done), 32'd1);
    chk("post total", 32'(o_result_total), 32'd1);
    i_rd_en = 1'b1;
    tick();
    i_rd_en = 1'b0;
    chk("post rd", {21'd0, o_rd_valid, o_rd_data}, 32'h63C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire
